dtree_feature_loader: RTL and testbench

//  Producer side of the decision-tree classifier interface. Receives one sample as a

---
 rtl/dtree_pkg.sv | 21 ++
 rtl/dtree_feature_loader.sv | 151 +++++++++++++++
 tb/tb_dtree_feature_loader.sv | 263 ++++++++++++++++++++++++++
 3 files changed

// File: rtl/dtree_pkg.sv
// Shared constants and state encoding for the decision-tree interface blocks.
// Every block that talks to the combinational tree sizes its buses from here.
package dtree_pkg;

  typedef enum logic [1:0] {
    LOAD = 2'd0,
    DROP = 2'd1,
    EVAL = 2'd2,
    OUT  = 2'd3
  } dtree_state_t;

  localparam int DTREE_NUM_FEAT = 5;
  localparam int DTREE_FEAT_W   = 8;
  localparam int DTREE_CLASS_W  = 5;

  // Bits needed to index n items, never less than one so n=1 still gives a legal vector.
  function automatic int dtree_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/dtree_feature_loader.sv
// Assembles a byte-stream sample onto the tree's parallel feature bus, waits for the tree
// to settle, then holds the captured class index on a valid/ready output until accepted.
module dtree_feature_loader
  import dtree_pkg::*;
#(
  parameter int NUM_FEAT = DTREE_NUM_FEAT,
  parameter int FEAT_W   = DTREE_FEAT_W,
  parameter int CLASS_W  = DTREE_CLASS_W,
  parameter int TREE_LAT = 0,
  parameter int CNT_W    = 16
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       s_valid,
  input  logic [FEAT_W-1:0]          s_data,
  input  logic                       s_last,
  output logic                       s_ready,
  output logic [NUM_FEAT*FEAT_W-1:0] feat_bus,
  output logic                       feat_valid,
  input  logic [CLASS_W-1:0]         class_in,
  output logic                       m_valid,
  output logic [CLASS_W-1:0]         m_class,
  input  logic                       m_ready,
  output logic                       err_frame,
  output logic [CNT_W-1:0]           sample_cnt
);

  localparam int IDX_W = dtree_width(NUM_FEAT);
  localparam int SET_W = dtree_width(TREE_LAT + 1);
  localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(NUM_FEAT - 1);
  localparam logic [SET_W-1:0] SET_INIT = SET_W'(TREE_LAT);

  dtree_state_t        state_reg;
  logic [IDX_W-1:0]    idx_reg;
  logic [SET_W-1:0]    settle_reg;
  logic                s_ready_reg;
  logic                feat_valid_reg;
  logic                m_valid_reg;
  logic [CLASS_W-1:0]  m_class_reg;
  logic                err_frame_reg;
  logic [CNT_W-1:0]    sample_cnt_reg;

  logic s_xfer;
  logic m_xfer;
  logic load_xfer;

  // s_ready_reg is only ever high in LOAD/DROP, so these never depend on s_valid combinationally.
  assign s_xfer    = s_valid & s_ready_reg;
  assign load_xfer = s_xfer & (state_reg == LOAD);
  assign m_xfer    = m_valid_reg & m_ready;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg      <= LOAD;
      idx_reg        <= '0;
      settle_reg     <= '0;
      s_ready_reg    <= 1'b0;
      feat_valid_reg <= 1'b0;
      m_valid_reg    <= 1'b0;
      m_class_reg    <= '0;
      err_frame_reg  <= 1'b0;
      sample_cnt_reg <= '0;
    end else begin
      err_frame_reg <= 1'b0;
      case (state_reg)
        LOAD: begin
          s_ready_reg <= 1'b1;
          if (s_xfer) begin
            if (idx_reg == IDX_LAST) begin
              idx_reg <= '0;
              if (s_last) begin
                state_reg      <= EVAL;
                settle_reg     <= SET_INIT;
                s_ready_reg    <= 1'b0;
                feat_valid_reg <= 1'b1;
              end else begin
                err_frame_reg <= 1'b1;
                state_reg     <= DROP;
              end
            end else if (s_last) begin
              err_frame_reg <= 1'b1;
              idx_reg       <= '0;
            end else begin
              idx_reg <= idx_reg + IDX_W'(1);
            end
          end
        end

        // Swallow the tail of an over-long frame; its error was already flagged.
        DROP: begin
          s_ready_reg <= 1'b1;
          if (s_xfer && s_last) begin
            state_reg <= LOAD;
          end
        end

        EVAL: begin
          s_ready_reg <= 1'b0;
          if (settle_reg == '0) begin
            m_class_reg    <= class_in;
            m_valid_reg    <= 1'b1;
            feat_valid_reg <= 1'b0;
            state_reg      <= OUT;
          end else begin
            settle_reg <= settle_reg - SET_W'(1);
          end
        end

        OUT: begin
          if (m_xfer) begin
            m_valid_reg    <= 1'b0;
            sample_cnt_reg <= sample_cnt_reg + CNT_W'(1);
            idx_reg        <= '0;
            s_ready_reg    <= 1'b1;
            state_reg      <= LOAD;
          end
        end

        default: begin
          state_reg <= LOAD;
        end
      endcase
    end
  end

  // One register lane per feature; a lane only changes when its byte arrives in LOAD.
  genvar gi;
  generate
    for (gi = 0; gi < NUM_FEAT; gi++) begin : g_lane
      logic [FEAT_W-1:0] lane_reg;

      always_ff @(posedge clk) begin
        if (rst) begin
          lane_reg <= '0;
        end else if (load_xfer && (idx_reg == IDX_W'(gi))) begin
          lane_reg <= s_data;
        end
      end

      assign feat_bus[gi*FEAT_W +: FEAT_W] = lane_reg;
    end
  endgenerate

  assign s_ready    = s_ready_reg;
  assign feat_valid = feat_valid_reg;
  assign m_valid    = m_valid_reg;
  assign m_class    = m_class_reg;
  assign err_frame  = err_frame_reg;
  assign sample_cnt = sample_cnt_reg;

endmodule

// File: tb/tb_dtree_feature_loader.sv
// Directed bench for dtree_feature_loader: a zero-latency instance for framing/back-pressure/reset
// and a TREE_LAT=2, 3-bit-counter instance for settle timing and counter wrap.
module tb_dtree_feature_loader;

  logic        clk = 1'b0;
  logic        rst;

  logic        s_valid, s_last, s_ready, feat_valid, m_valid, m_ready, err_frame;
  logic [7:0]  s_data;
  logic [39:0] feat_bus;
  logic [4:0]  class_in, m_class;
  logic [15:0] sample_cnt;

  logic        s_valid2, s_last2, s_ready2, feat_valid2, m_valid2, m_ready2, err_frame2;
  logic [7:0]  s_data2;
  logic [39:0] feat_bus2;
  logic [4:0]  class_in2, m_class2;
  logic [2:0]  sample_cnt2;

  logic        fn_mode;
  logic [4:0]  class_const;

  int checks = 0;
  int errors = 0;
  logic [4:0] exp_q[$];
  logic [4:0] exp2_q[$];

  always #5 clk = ~clk;

  // Tree stub: a constant class, or the sum of each feature's low five bits.
  always_comb begin
    class_in = class_const;
    if (fn_mode) begin
      class_in = feat_bus[4:0] + feat_bus[12:8] + feat_bus[20:16] + feat_bus[28:24] + feat_bus[36:32];
    end
  end

  dtree_feature_loader u_dut (
    .clk(clk), .rst(rst), .s_valid(s_valid), .s_data(s_data), .s_last(s_last),
    .s_ready(s_ready), .feat_bus(feat_bus), .feat_valid(feat_valid), .class_in(class_in),
    .m_valid(m_valid), .m_class(m_class), .m_ready(m_ready), .err_frame(err_frame),
    .sample_cnt(sample_cnt)
  );

  dtree_feature_loader #(.TREE_LAT(2), .CNT_W(3)) u_dut2 (
    .clk(clk), .rst(rst), .s_valid(s_valid2), .s_data(s_data2), .s_last(s_last2),
    .s_ready(s_ready2), .feat_bus(feat_bus2), .feat_valid(feat_valid2), .class_in(class_in2),
    .m_valid(m_valid2), .m_class(m_class2), .m_ready(m_ready2), .err_frame(err_frame2),
    .sample_cnt(sample_cnt2)
  );

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic send_byte(input bit sel, input logic [7:0] d, input bit last);
    int n = 0;
    if (!sel) begin s_valid = 1'b1; s_data = d; s_last = last; end
    else begin s_valid2 = 1'b1; s_data2 = d; s_last2 = last; end
    while (((sel ? s_ready2 : s_ready) !== 1'b1) && (n < 50)) begin
      step();
      n++;
    end
    chk("send_ready", sel ? s_ready2 : s_ready, 1);
    step();
    if (!sel) begin s_valid = 1'b0; s_last = 1'b0; end
    else begin s_valid2 = 1'b0; s_last2 = 1'b0; end
  endtask

  // Sends n bytes taken LSB-first from b, flagging the last one.
  task automatic send_frame(input bit sel, input logic [63:0] b, input int n);
    for (int k = 0; k < n; k++) begin
      send_byte(sel, b[k*8 +: 8], (k == n - 1));
    end
  endtask

  task automatic wait_mvalid(input bit sel, input string tag);
    int n = 0;
    while (((sel ? m_valid2 : m_valid) !== 1'b1) && (n < 50)) begin
      step();
      n++;
    end
    chk({tag, "_mvalid"}, sel ? m_valid2 : m_valid, 1);
  endtask

  // Pops the scoreboard at the output handshake; assumes m_ready is high.
  task automatic recv(input bit sel, input string tag);
    logic [4:0] e;
    wait_mvalid(sel, tag);
    if (!sel) e = (exp_q.size() > 0) ? exp_q.pop_front() : 5'bx;
    else      e = (exp2_q.size() > 0) ? exp2_q.pop_front() : 5'bx;
    chk({tag, "_class"}, sel ? m_class2 : m_class, e);
    step();
    chk({tag, "_mvalid_drop"}, sel ? m_valid2 : m_valid, 0);
  endtask

  initial begin
    rst = 1'b1;
    s_valid = 0; s_data = 0; s_last = 0; m_ready = 1;
    s_valid2 = 0; s_data2 = 0; s_last2 = 0; m_ready2 = 1; class_in2 = 0;
    fn_mode = 0; class_const = 5'd24;

    // Reset state
    step();
    chk("rst_s_ready", s_ready, 0);
    chk("rst_feat_bus", feat_bus, 0);
    chk("rst_feat_valid", feat_valid, 0);
    chk("rst_m_valid", m_valid, 0);
    chk("rst_m_class", m_class, 0);
    chk("rst_err", err_frame, 0);
    chk("rst_cnt", sample_cnt, 0);
    rst = 1'b0;
    step();
    chk("post_rst_s_ready", s_ready, 1);

    // 1: basic frame, latency T+1 / T+2
    exp_q.push_back(5'd24);
    send_frame(0, 64'h50_40_30_20_10, 5);
    chk("t1_feat_valid", feat_valid, 1);
    chk("t1_feat_bus", feat_bus, 40'h5040302010);
    chk("t1_s_ready_eval", s_ready, 0);
    chk("t1_m_valid_early", m_valid, 0);
    step();
    chk("t1_m_valid", m_valid, 1);
    chk("t1_m_class", m_class, exp_q.pop_front());
    chk("t1_feat_valid_out", feat_valid, 0);
    step();
    chk("t1_m_valid_drop", m_valid, 0);
    chk("t1_cnt", sample_cnt, 1);
    chk("t1_s_ready_back", s_ready, 1);

    // 2: back-pressure for 10 cycles with a byte waiting
    m_ready = 0;
    exp_q.push_back(5'd24);
    send_frame(0, 64'h05_04_03_02_01, 5);
    wait_mvalid(0, "t2");
    s_valid = 1; s_data = 8'hAA;
    for (int i = 0; i < 10; i++) begin
      chk("t2_hold_m_valid", m_valid, 1);
      chk("t2_hold_m_class", m_class, 24);
      chk("t2_hold_s_ready", s_ready, 0);
      step();
    end
    s_valid = 0;
    chk("t2_feat_bus_frozen", feat_bus, 40'h0504030201);
    m_ready = 1;
    chk("t2_m_class", m_class, exp_q.pop_front());
    step();
    chk("t2_cnt", sample_cnt, 2);
    fn_mode = 1;
    exp_q.push_back(5'd31);
    send_frame(0, 64'h55_44_33_22_11, 5);
    recv(0, "t2_fn");
    chk("t2_fn_cnt", sample_cnt, 3);
    fn_mode = 0;

    // 3: short frame
    class_const = 5'd7;
    send_byte(0, 8'hA1, 0);
    send_byte(0, 8'hA2, 0);
    send_byte(0, 8'hA3, 1);
    chk("t3_err_pulse", err_frame, 1);
    chk("t3_feat_valid", feat_valid, 0);
    step();
    chk("t3_err_clear", err_frame, 0);
    chk("t3_no_m_valid", m_valid, 0);
    exp_q.push_back(5'd7);
    send_frame(0, 64'hB5_B4_B3_B2_B1, 5);
    recv(0, "t3_good");
    chk("t3_cnt", sample_cnt, 4);

    // 4: long frame
    for (int k = 1; k <= 4; k++) send_byte(0, 8'hC0 + 8'(k), 0);
    chk("t4_no_err_early", err_frame, 0);
    send_byte(0, 8'hC5, 0);
    chk("t4_err_pulse", err_frame, 1);
    send_byte(0, 8'hC6, 0);
    chk("t4_err_b6", err_frame, 0);
    send_byte(0, 8'hC7, 1);
    chk("t4_err_b7", err_frame, 0);
    step();
    chk("t4_no_m_valid", m_valid, 0);
    chk("t4_feat_valid", feat_valid, 0);
    chk("t4_dropped_bytes", feat_bus, 40'hC5C4C3C2C1);
    class_const = 5'd3;
    exp_q.push_back(5'd3);
    send_frame(0, 64'hD5_D4_D3_D2_D1, 5);
    chk("t4_good_bus", feat_bus, 40'hD5D4D3D2D1);
    recv(0, "t4_good");
    chk("t4_cnt", sample_cnt, 5);

    // 5: TREE_LAT=2, class changes one cycle after feat_valid
    exp2_q.push_back(5'd17);
    send_frame(1, 64'h0E_0D_0C_0B_0A, 5);
    chk("t5_feat_valid", feat_valid2, 1);
    chk("t5_m_valid_t1", m_valid2, 0);
    class_in2 = 5'd17;
    step();
    chk("t5_m_valid_t2", m_valid2, 0);
    chk("t5_feat_valid_t2", feat_valid2, 1);
    step();
    chk("t5_m_valid_t3", m_valid2, 0);
    step();
    chk("t5_m_valid_t4", m_valid2, 1);
    chk("t5_m_class", m_class2, exp2_q.pop_front());
    step();
    chk("t5_cnt", sample_cnt2, 1);
    for (int f = 0; f < 7; f++) begin
      exp2_q.push_back(5'd17);
      send_frame(1, 64'h60_50_40_30_20 + 64'(f), 5);
      recv(1, "t5_wrap");
    end
    chk("t5_cnt_wrap", sample_cnt2, 0);

    // 6: reset mid-frame and in OUT
    send_byte(0, 8'hE1, 0);
    send_byte(0, 8'hE2, 0);
    send_byte(0, 8'hE3, 0);
    rst = 1;
    step();
    chk("t6a_s_ready", s_ready, 0);
    chk("t6a_feat_bus", feat_bus, 0);
    chk("t6a_feat_valid", feat_valid, 0);
    chk("t6a_err", err_frame, 0);
    chk("t6a_cnt", sample_cnt, 0);
    rst = 0;
    step();
    chk("t6a_s_ready_back", s_ready, 1);
    m_ready = 0;
    class_const = 5'd9;
    send_frame(0, 64'hF5_F4_F3_F2_F1, 5);
    wait_mvalid(0, "t6b");
    rst = 1;
    step();
    chk("t6b_m_valid", m_valid, 0);
    chk("t6b_m_class", m_class, 0);
    chk("t6b_cnt", sample_cnt, 0);
    rst = 0;
    m_ready = 1;
    for (int i = 0; i < 3; i++) begin
      step();
      chk("t6b_no_output", m_valid, 0);
    end
    class_const = 5'd12;
    exp_q.push_back(5'd12);
    send_frame(0, 64'h15_14_13_12_11, 5);
    recv(0, "t6_good");
    chk("t6_cnt", sample_cnt, 1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
